// File: rtl/err_stat_accum.sv
// err_stat_accum: per-channel error statistics between approximate and exact
// results over a window of 2**WIN_LOG2 accepted samples. Each channel gets a
// signed sum of errors and an unsigned sum of squared errors. Both are sized
// so that they cannot overflow.
// Optional feature macro: ERR_STAT_MAXABS_EN. It adds the err_maxabs output,
// which holds the per-channel maximum |error| over the window.
module err_stat_accum #(
  parameter int W        = 32,
  parameter int CH       = 2,
  parameter int WIN_LOG2 = 10,
  localparam int SUM_W   = W + 1 + WIN_LOG2,
  localparam int SQ_W    = 2 * (W + 1) + WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*W-1:0]     approx_data,
  input  logic [CH*W-1:0]     exact_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*SUM_W-1:0] err_sum,
  output logic [CH*SQ_W-1:0]  err_sumsq,
`ifdef ERR_STAT_MAXABS_EN
  output logic [CH*(W+1)-1:0] err_maxabs,
`endif
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state_reg, state_next;
  logic [WIN_LOG2-1:0] cnt_reg;
  logic                flush_reg;
  logic                s1_valid_reg;
  logic                out_valid_reg;
  logic                accept;
  logic                last_sample;
  logic                abort_act;
  logic                handshake;
  logic                clear_acc;

  assign accept      = in_valid && in_ready;
  assign last_sample = accept && (cnt_reg == {WIN_LOG2{1'b1}});
  assign abort_act   = abort && ((state_reg == RUN) || (state_reg == FLUSH));
  assign handshake   = (state_reg == DONE) && out_valid_reg && out_ready;
  // A new window starts from IDLE, or straight out of DONE on the consuming edge.
  assign clear_acc   = ((state_reg == IDLE) && start) || (handshake && start);
  assign out_valid   = out_valid_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. Abort wins over everything while a window is in flight.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (abort) state_next = IDLE;
             else if (last_sample) state_next = FLUSH;
      FLUSH: if (abort) state_next = IDLE;
             else if (flush_reg) state_next = DONE;
      DONE:  if (out_valid_reg && out_ready) state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = (state_reg == RUN);
    busy     = (state_reg == RUN) || (state_reg == FLUSH);
  end

  // Control: sample counter, flush timer, stage-1 valid and the registered out_valid.
  // out_valid rises one cycle after entering DONE, once stage 2 has settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      flush_reg     <= 1'b0;
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (clear_acc)   cnt_reg <= '0;
      else if (accept) cnt_reg <= cnt_reg + 1'b1;
      flush_reg     <= (state_reg == FLUSH) && (state_next == FLUSH);
      s1_valid_reg  <= accept && !abort;
      out_valid_reg <= (state_reg == DONE) && (state_next == DONE);
    end
  end

  genvar gi;
  for (gi = 0; gi < CH; gi++) begin : g_ch
    logic signed [W:0]       e_next;
    logic signed [W:0]       e_reg;
    logic signed [SUM_W-1:0] sum_reg;
    logic [SQ_W-1:0]         sq_reg;
    logic [2*W+1:0]          sq_term;

    // The difference is taken one bit wider than the data, so it never wraps.
    assign e_next  = $signed({approx_data[gi*W+W-1], approx_data[gi*W +: W]})
                   - $signed({exact_data[gi*W+W-1], exact_data[gi*W +: W]});
    // The low 2W+2 bits of the sign-extended product are the exact square.
    assign sq_term = {{(W+1){e_reg[W]}}, e_reg} * {{(W+1){e_reg[W]}}, e_reg};

    // Stage 1: capture the error of each accepted sample.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         e_reg <= '0;
      else if (accept) e_reg <= e_next;
    end

    // Stage 2: accumulate the error and the squared error. Abort discards stage 1.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_reg <= '0;
        sq_reg  <= '0;
      end else if (clear_acc) begin
        sum_reg <= '0;
        sq_reg  <= '0;
      end else if (s1_valid_reg && !abort_act) begin
        sum_reg <= sum_reg + {{(SUM_W-W-1){e_reg[W]}}, e_reg};
        sq_reg  <= sq_reg + {{WIN_LOG2{1'b0}}, sq_term};
      end
    end

    assign err_sum[gi*SUM_W +: SUM_W] = sum_reg;
    assign err_sumsq[gi*SQ_W +: SQ_W] = sq_reg;

`ifdef ERR_STAT_MAXABS_EN
    logic [W:0] abs_e;
    logic [W:0] max_reg;
    // |e| fits in W+1 unsigned bits, including the most negative error.
    assign abs_e = e_reg[W] ? (~e_reg + 1'b1) : e_reg;

    // Stage 2: track the running maximum |e| alongside the sums.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          max_reg <= '0;
      else if (clear_acc)                               max_reg <= '0;
      else if (s1_valid_reg && !abort_act && (abs_e > max_reg)) max_reg <= abs_e;
    end

    assign err_maxabs[gi*(W+1) +: (W+1)] = max_reg;
`endif
  end

endmodule

// File: tb/tb_err_stat_accum.sv
// Scoreboard bench for err_stat_accum with W=32, CH=2 and WIN_LOG2=2.
// The stimulus pushes the hand-computed window results into a queue. A monitor
// pops one entry on each out_valid/out_ready handshake and compares it.
module tb_err_stat_accum;
  localparam int W     = 32;
  localparam int CH    = 2;
  localparam int WL    = 2;
  localparam int SUM_W = W + 1 + WL;
  localparam int SQ_W  = 2 * (W + 1) + WL;

  typedef struct {
    logic signed [SUM_W-1:0] s0;
    logic signed [SUM_W-1:0] s1;
    logic [SQ_W-1:0]         q0;
    logic [SQ_W-1:0]         q1;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic                in_valid;
  logic                in_ready;
  logic [CH*W-1:0]     approx_data;
  logic [CH*W-1:0]     exact_data;
  logic                out_valid;
  logic                out_ready;
  logic [CH*SUM_W-1:0] err_sum;
  logic [CH*SQ_W-1:0]  err_sumsq;
  logic                busy;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   done_cnt   = 0;

  err_stat_accum #(.W(W), .CH(CH), .WIN_LOG2(WL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .approx_data(approx_data), .exact_data(exact_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_sum(err_sum), .err_sumsq(err_sumsq), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [SQ_W-1:0] got, input logic [SQ_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one sample pair, wait for it to be accepted, then idle for gap cycles.
  task automatic send(input logic [W-1:0] a0, input logic [W-1:0] x0,
                      input logic [W-1:0] a1, input logic [W-1:0] x1, input int gap);
    int n = 0;
    approx_data = {a1, a0};
    exact_data  = {x1, x0};
    in_valid    = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_accept_timeout", {67'd0, in_ready}, 68'd1);
    tick();
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      approx_data = {$urandom, $urandom};
      exact_data  = {$urandom, $urandom};
      tick();
    end
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_cnt < n && k < 100) begin
      tick();
      k++;
    end
    check("window_done_timeout", 68'(done_cnt), 68'(n));
  endtask

  // Monitor: compare each delivered statistics set against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out_valid: got=1 expected=0");
        end else begin
          e = exp_q.pop_front();
          $display("window %0d: sum0=%0d sum1=%0d sq0=%0d sq1=%0d", done_cnt,
                   $signed(err_sum[SUM_W-1:0]), $signed(err_sum[2*SUM_W-1:SUM_W]),
                   err_sumsq[SQ_W-1:0], err_sumsq[2*SQ_W-1:SQ_W]);
          check("err_sum_ch0",   $signed(err_sum[SUM_W-1:0]), e.s0);
          check("err_sum_ch1",   $signed(err_sum[2*SUM_W-1:SUM_W]), e.s1);
          check("err_sumsq_ch0", err_sumsq[SQ_W-1:0], e.q0);
          check("err_sumsq_ch1", err_sumsq[2*SQ_W-1:SQ_W], e.q1);
          done_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CH*SUM_W+CH*SQ_W-1:0] snap;
    int k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    approx_data = '0; exact_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {67'd0, out_valid}, 68'd0);
    check("rst_in_ready",  {67'd0, in_ready}, 68'd0);
    check("rst_busy",      {67'd0, busy}, 68'd0);
    check("rst_err_sum",   {67'd0, |err_sum}, 68'd0);
    check("rst_err_sumsq", {67'd0, |err_sumsq}, 68'd0);
    rst = 1'b0;
    tick();

    // Window 1: mixed-sign errors, back-to-back, with latency checks.
    exp_q.push_back('{35'sd4, -35'sd4, 68'd14, 68'd4});
    start_win();
    check("t1_busy_run", {67'd0, busy}, 68'd1);
    send(32'd5, 32'd2, 32'd0, 32'd1, 0);
    send(32'd4, 32'd5, 32'd0, 32'd1, 0);
    send(32'd7, 32'd5, 32'd0, 32'd1, 0);
    send(32'd10, 32'd10, 32'd0, 32'd1, 0);
    check("t1_in_ready_after_last", {67'd0, in_ready}, 68'd0);
    check("t1_out_valid_e0", {67'd0, out_valid}, 68'd0);
    tick();
    check("t1_out_valid_e1", {67'd0, out_valid}, 68'd0);
    tick();
    check("t1_out_valid_e2", {67'd0, out_valid}, 68'd0);
    tick();
    check("t1_out_valid_e3", {67'd0, out_valid}, 68'd1);
    wait_done(1);

    // Window 2: extreme operands with in_valid gaps, no wrap expected.
    exp_q.push_back('{-35'sd17179869180, 35'sd0, 68'h3_FFFF_FFF8_0000_0004, 68'd0});
    start_win();
    for (int i = 0; i < 4; i++) send(32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0, 2);
    wait_done(2);

    // Window 3: hold in DONE, then consume and restart on the same edge.
    exp_q.push_back('{-35'sd28, 35'sd400, 68'd196, 68'd40000});
    out_ready = 1'b0;
    start_win();
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFD, 32'd4, 32'd100, 32'd0, 0);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("t3_out_valid_wait", {67'd0, out_valid}, 68'd1);
    snap = {err_sum, err_sumsq};
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_out_valid", {67'd0, out_valid}, 68'd1);
      check("t3_hold_stable", {67'd0, snap == {err_sum, err_sumsq}}, 68'd1);
    end
    exp_q.push_back('{35'sd8, -35'sd20, 68'd16, 68'd100});
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_restart_cleared", {67'd0, |err_sum}, 68'd0);
    check("t3_restart_run", {67'd0, in_ready}, 68'd1);
    for (int i = 0; i < 4; i++) send(32'd2, 32'd0, 32'd0, 32'd5, 0);
    wait_done(4);

    // Window 4: abort after two samples, then a clean window with start noise.
    start_win();
    send(32'd9, 32'd0, 32'd9, 32'd0, 0);
    send(32'd9, 32'd0, 32'd9, 32'd0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_busy", {67'd0, busy}, 68'd0);
    check("t4_abort_in_ready", {67'd0, in_ready}, 68'd0);
    repeat (6) tick();
    exp_q.push_back('{35'sd4, 35'sd0, 68'd4, 68'd0});
    start_win();
    send(32'd1, 32'd0, 32'd0, 32'd0, 0);
    start = 1'b1;
    send(32'd1, 32'd0, 32'd0, 32'd0, 0);
    start = 1'b0;
    send(32'd1, 32'd0, 32'd0, 32'd0, 0);
    send(32'd1, 32'd0, 32'd0, 32'd0, 0);
    wait_done(5);

    // Window 5: asynchronous reset after three samples.
    start_win();
    for (int i = 0; i < 3; i++) send(32'd6, 32'd1, 32'd0, 32'd0, 0);
    check("t5_pre_rst_sum", $signed(err_sum[SUM_W-1:0]), 68'd10);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_err_sum",   {67'd0, |err_sum}, 68'd0);
    check("t5_rst_err_sumsq", {67'd0, |err_sumsq}, 68'd0);
    check("t5_rst_out_valid", {67'd0, out_valid}, 68'd0);
    check("t5_rst_in_ready",  {67'd0, in_ready}, 68'd0);
    check("t5_rst_busy",      {67'd0, busy}, 68'd0);
    #2;
    rst = 1'b0;
    repeat (5) tick();
    check("t5_post_rst_in_ready", {67'd0, in_ready}, 68'd0);
    check("t5_post_rst_busy", {67'd0, busy}, 68'd0);
    check("scoreboard_empty", 68'(exp_q.size()), 68'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/err_stat_accum.md
ERR_STAT_ACCUM -- requirements
Module: err_stat_accum

Interface
REQ-001 SHALL have parameter W, default 32, data width per channel of approximate and exact results.
REQ-002 SHALL have parameter CH, default 2, number of independent channels.
REQ-003 SHALL have parameter WIN_LOG2, default 10, window length = 2**WIN_LOG2 samples.
REQ-004 SHALL derive SUM_W = W+1+WIN_LOG2 and SQ_W = 2*(W+1)+WIN_LOG2, not overridable.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 start  input  1  begin new window; sampled in IDLE or DONE.
REQ-009 abort  input  1  synchronous abandon of the current window.
REQ-010 in_valid  input  1  sample pair valid.
REQ-011 in_ready  output  1  sample accepted when in_valid and in_ready are both high.
REQ-012 approx_data  input  CH*W  approximate results, channel k at bits [k*W +: W], two's complement.
REQ-013 exact_data  input  CH*W  exact reference results, same packing.
REQ-014 out_valid  output  1  statistics valid.
REQ-015 out_ready  input  1  consumer accepts statistics.
REQ-016 err_sum  output  CH*SUM_W  per-channel signed sum of errors.
REQ-017 err_sumsq  output  CH*SQ_W  per-channel unsigned sum of squared errors.
REQ-018 busy  output  1  high in RUN and FLUSH.

Function
REQ-019 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-020 IDLE->RUN on start; accumulators and sample counter cleared on that edge.
REQ-021 in_ready SHALL be 1 only in RUN.
REQ-022 Per accepted sample, per channel: e = signed(approx) - signed(exact), computed in W+1 bits with no wrap.
REQ-023 Stage 1 registers e; stage 2 adds e to err_sum (sign-extended) and e*e to err_sumsq.
REQ-024 Counter SHALL count accepted samples; acceptance of sample 2**WIN_LOG2 SHALL move RUN->FLUSH.
REQ-025 FLUSH SHALL last 2 cycles; out_valid SHALL rise exactly 3 cycles after the edge accepting the last sample.
REQ-026 In DONE, out_valid, err_sum, err_sumsq SHALL hold stable until out_ready=1; that edge leaves DONE.
REQ-027 DONE with out_ready=1 and start=1 on the same edge SHALL go directly to RUN with cleared accumulators; DONE with out_ready=1 and start=0 goes to IDLE.
REQ-028 start in RUN or FLUSH SHALL be ignored.
REQ-029 in_valid gaps SHALL not affect results; only accepted samples count.
REQ-030 abort in RUN or FLUSH SHALL go to IDLE next edge with no out_valid; pipeline contents discarded; abort takes priority over start.
REQ-031 By construction of SUM_W and SQ_W, accumulators SHALL never overflow.

Reset
REQ-032 rst SHALL force IDLE, counter 0, pipeline 0, err_sum 0, err_sumsq 0, out_valid 0, in_ready 0, busy 0, independent of clk.
REQ-033 rst mid-window SHALL discard the window; no out_valid follows until a new start.

Configuration
REQ-034 Macro ERR_STAT_MAXABS_EN: when defined, SHALL add output err_maxabs (CH*(W+1), unsigned), per-channel max |e| over the window, updated in stage 2, cleared with the accumulators, held in DONE, 0 on reset.
REQ-035 Without ERR_STAT_MAXABS_EN, port and logic SHALL be absent; all other behaviour identical.

Verification (W=32, CH=2, WIN_LOG2=2)
REQ-036 ch0 errors +3,-1,+2,0 and ch1 approx=0/exact=1 ×4 -> err_sum ch0=4, ch1=-4; err_sumsq ch0=14, ch1=4; maxabs 3,1.
REQ-037 approx=32'h80000000, exact=32'h7FFFFFFF ×4 on ch0 -> err_sum=-17179869180, err_sumsq=4*(2**32-1)**2, no wrap.
REQ-038 4 samples back-to-back -> out_valid rises exactly 3 cycles after the 4th acceptance; in_ready=0 from the cycle after.
REQ-039 out_ready held 0 for 10 cycles in DONE -> outputs stable; out_ready=1 with start=1 -> RUN, err_sum cleared, second window correct.
REQ-040 abort after 2 samples, then start and 4 samples of e=+1 -> no out_valid for first window; second gives err_sum=4, err_sumsq=4.
REQ-041 rst pulse asynchronous to clk after 3 samples -> all outputs 0 immediately; in_ready stays 0 until start.
